// File: rtl/raw_pixel_unpacker_pkg.sv
// Shared CSI-2 data-type codes and pixel group types for the raw pixel unpacker.
// Pixel n of a group occupies bits [10n+9:10n]; pixel 0 is first on the line.
package raw_pixel_unpacker_pkg;

  localparam logic [7:0] CSI2_YUV422_8    = 8'h1E;
  localparam logic [7:0] CSI2_RGB888      = 8'h24;
  localparam logic [7:0] CSI2_RAW6        = 8'h28;
  localparam logic [7:0] CSI2_RAW7        = 8'h29;
  localparam logic [7:0] CSI2_RAW8        = 8'h2A;
  localparam logic [7:0] CSI2_RAW10       = 8'h2B;
  localparam logic [7:0] CSI2_RAW12       = 8'h2C;
  localparam logic [7:0] CSI2_RAW14       = 8'h2D;
  localparam logic [7:0] CSI2_SHORT_MIN   = 8'h00;
  localparam logic [7:0] CSI2_SHORT_MAX   = 8'h0F;

  typedef logic [3:0][9:0] pixel_group_t;

  // RAW8 pixels are widened to 10 bits by appending two zero LSBs.
  function automatic pixel_group_t raw8_group(input logic [31:0] word);
    pixel_group_t grp;
    grp = '0;
    for (int n = 0; n < 4; n++) begin
      grp[n] = {word[8*n +: 8], 2'b00};
    end
    return grp;
  endfunction

endpackage

// File: rtl/raw_pixel_unpacker_if.sv
// Word-stream input and pixel-group output bundle of the raw pixel unpacker.
// The master side is the packet receiver / pixel pipeline; the slave side is the unpacker.
interface raw_pixel_unpacker_if;

  logic        packet_start;
  logic [31:0] image_data;
  logic        image_data_enable;
  logic [7:0]  image_data_type;
  logic [15:0] word_count;
  logic [39:0] pixel_data;
  logic        pixel_valid;
  logic        line_end;
  logic        alignment_error;

  modport master (
    output packet_start, image_data, image_data_enable, image_data_type, word_count,
    input  pixel_data, pixel_valid, line_end, alignment_error
  );

  modport slave (
    input  packet_start, image_data, image_data_enable, image_data_type, word_count,
    output pixel_data, pixel_valid, line_end, alignment_error
  );

endinterface

// File: rtl/raw_pixel_unpacker_raw10_group_decode.sv
// Combinational RAW10 decode: five packed bytes (B0 in bits [7:0]) to four 10-bit pixels.
// B0..B3 carry the pixel MSBs; B4 carries the two LSBs of each pixel.
module raw10_group_decode
  import raw_pixel_unpacker_pkg::*;
(
  input  logic [39:0]  bytes_i,
  output pixel_group_t group_o
);

  always_comb begin
    group_o = '0;
    for (int n = 0; n < 4; n++) begin
      group_o[n] = {bytes_i[8*n +: 8], bytes_i[32 + 2*n +: 2]};
    end
  end

endmodule

// File: rtl/raw_pixel_unpacker.sv
// Unpacks the 32-bit CSI-2 payload word stream into 4-pixel groups (RAW8/RAW10),
// carrying RAW10 bytes across word boundaries in an 8-byte buffer.
module raw_pixel_unpacker
  import raw_pixel_unpacker_pkg::*;
#(
  parameter logic [7:0] RAW8_TYPE  = CSI2_RAW8,
  parameter logic [7:0] RAW10_TYPE = CSI2_RAW10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  raw_pixel_unpacker_if.slave  bus
);

  logic [63:0]  buf_q, buf_d;
  logic [3:0]   fill_q, fill_d;
  logic [16:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]   type_q, type_d;
  logic         type_vld_q, type_vld_d;
  logic         err_latch_q, err_latch_d;
  pixel_group_t pixel_data_q, pixel_data_d;
  logic         pixel_valid_q, pixel_valid_d;
  logic         line_end_q, line_end_d;
  logic         align_err_q, align_err_d;

  logic [7:0]   cur_type_s;
  logic [63:0]  appended_s;
  logic [3:0]   fill_sum_s;
  logic [3:0]   fill_rem_s;
  logic [16:0]  byte_cnt_sum_s;
  logic [16:0]  consumed_s;
  pixel_group_t raw10_group_s;

  // The first enable of a packet sees the live type; later enables use the latched one.
  assign cur_type_s     = type_vld_q ? type_q : bus.image_data_type;
  assign appended_s     = buf_q | ({32'h0000_0000, bus.image_data} << {fill_q, 3'b000});
  assign fill_sum_s     = fill_q + 4'd4;
  assign fill_rem_s     = fill_sum_s - 4'd5;
  assign byte_cnt_sum_s = byte_cnt_q + 17'd4;
  assign consumed_s     = byte_cnt_sum_s - {13'd0, fill_rem_s};

  raw10_group_decode u_raw10_decode (
    .bytes_i (appended_s[39:0]),
    .group_o (raw10_group_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    buf_d         = buf_q;
    fill_d        = fill_q;
    byte_cnt_d    = byte_cnt_q;
    type_d        = type_q;
    type_vld_d    = type_vld_q;
    err_latch_d   = err_latch_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    line_end_d    = 1'b0;
    align_err_d   = 1'b0;

    if (bus.packet_start) begin
      if (type_vld_q && (type_q == RAW10_TYPE) && (fill_q != 4'd0) && (fill_q <= 4'd4)) begin
        align_err_d = 1'b1;
      end else begin
        align_err_d = 1'b0;
      end
      buf_d       = 64'd0;
      fill_d      = 4'd0;
      byte_cnt_d  = 17'd0;
      type_vld_d  = 1'b0;
      err_latch_d = 1'b0;
    end else if (bus.image_data_enable) begin
      byte_cnt_d = byte_cnt_sum_s;
      type_d     = cur_type_s;
      type_vld_d = 1'b1;
      if (cur_type_s == RAW10_TYPE) begin
        if (fill_sum_s >= 4'd5) begin
          pixel_data_d  = raw10_group_s;
          pixel_valid_d = 1'b1;
          line_end_d    = (consumed_s >= {1'b0, bus.word_count});
          buf_d         = appended_s >> 7'd40;
          fill_d        = fill_rem_s;
        end else begin
          buf_d  = appended_s;
          fill_d = fill_sum_s;
        end
      end else if (cur_type_s == RAW8_TYPE) begin
        pixel_data_d  = raw8_group(bus.image_data);
        pixel_valid_d = 1'b1;
        line_end_d    = (byte_cnt_sum_s >= {1'b0, bus.word_count});
      end else begin
        // Unsupported type: bytes are dropped, only the first enable is reported.
        if (!err_latch_q) begin
          align_err_d = 1'b1;
          err_latch_d = 1'b1;
        end else begin
          align_err_d = 1'b0;
        end
      end
    end else begin
      pixel_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q         <= 64'd0;
      fill_q        <= 4'd0;
      byte_cnt_q    <= 17'd0;
      type_q        <= 8'd0;
      type_vld_q    <= 1'b0;
      err_latch_q   <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      line_end_q    <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      fill_q        <= fill_d;
      byte_cnt_q    <= byte_cnt_d;
      type_q        <= type_d;
      type_vld_q    <= type_vld_d;
      err_latch_q   <= err_latch_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      line_end_q    <= line_end_d;
      align_err_q   <= align_err_d;
    end
  end

  assign bus.pixel_data      = pixel_data_q;
  assign bus.pixel_valid     = pixel_valid_q;
  assign bus.line_end        = line_end_q;
  assign bus.alignment_error = align_err_q;

endmodule

// File: tb/tb_raw_pixel_unpacker.sv
// Directed self-checking bench for raw_pixel_unpacker: RAW10/RAW8 decode,
// line_end, alignment errors, unsupported types and asynchronous reset.
module tb_raw_pixel_unpacker;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  int   err_pulses;
  logic seen;

  raw_pixel_unpacker_if bus_if ();

  raw_pixel_unpacker u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, returns just after the rising edge that samples them.
  task automatic cycle(input logic ps, input logic en, input logic [31:0] d);
    @(negedge clock);
    bus_if.packet_start      = ps;
    bus_if.image_data_enable = en;
    bus_if.image_data        = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus_if.packet_start      = 1'b0;
    bus_if.image_data        = 32'd0;
    bus_if.image_data_enable = 1'b0;
    bus_if.image_data_type   = 8'h00;
    bus_if.word_count        = 16'd0;

    // 1. reset state and 100 idle cycles
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", {39'd0, bus_if.pixel_valid}, 40'd0);
    check("rst_data", bus_if.pixel_data, 40'd0);
    check("rst_err", {39'd0, bus_if.alignment_error}, 40'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      seen = seen | bus_if.pixel_valid | bus_if.line_end | bus_if.alignment_error;
    end
    check("idle_quiet", {39'd0, seen}, 40'd0);

    // 2. RAW10, word_count 20, bytes 0x01..0x14
    bus_if.image_data_type = 8'h2B;
    bus_if.word_count      = 16'd20;
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0403_0201);
    check("r10_w1_valid", {39'd0, bus_if.pixel_valid}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0807_0605);
    check("r10_g0_valid", {39'd0, bus_if.pixel_valid}, 40'd1);
    check("r10_g0_data", bus_if.pixel_data, {10'h010, 10'h00C, 10'h009, 10'h005});
    check("r10_g0_le", {39'd0, bus_if.line_end}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0C0B_0A09);
    check("r10_g1_p0", {30'd0, bus_if.pixel_data[9:0]}, 40'h01A);
    check("r10_g1_le", {39'd0, bus_if.line_end}, 40'd0);
    cycle(1'b0, 1'b1, 32'h100F_0E0D);
    check("r10_g2_p0", {30'd0, bus_if.pixel_data[9:0]}, 40'h02F);
    check("r10_g2_le", {39'd0, bus_if.line_end}, 40'd0);
    cycle(1'b0, 1'b1, 32'h1413_1211);
    check("r10_g3_valid", {39'd0, bus_if.pixel_valid}, 40'd1);
    check("r10_g3_p0", {30'd0, bus_if.pixel_data[9:0]}, 40'h040);
    check("r10_g3_le", {39'd0, bus_if.line_end}, 40'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check("r10_after_valid", {39'd0, bus_if.pixel_valid}, 40'd0);

    // 3. RAW8, word_count 8
    bus_if.image_data_type = 8'h2A;
    bus_if.word_count      = 16'd8;
    cycle(1'b1, 1'b0, 32'd0);
    check("r8_ps_noerr", {39'd0, bus_if.alignment_error}, 40'd0);
    cycle(1'b0, 1'b1, 32'h4433_2211);
    check("r8_g0_data", bus_if.pixel_data, {10'h110, 10'h0CC, 10'h088, 10'h044});
    check("r8_g0_le", {39'd0, bus_if.line_end}, 40'd0);
    cycle(1'b0, 1'b1, 32'h8877_6655);
    check("r8_g1_p0", {30'd0, bus_if.pixel_data[9:0]}, 40'h154);
    check("r8_g1_le", {39'd0, bus_if.line_end}, 40'd1);

    // 4. RAW10 packet cut short: 3 bytes left over
    bus_if.image_data_type = 8'h2B;
    bus_if.word_count      = 16'd8;
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0403_0201);
    check("short_w1_valid", {39'd0, bus_if.pixel_valid}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0807_0605);
    check("short_g0_p0", {30'd0, bus_if.pixel_data[9:0]}, 40'h005);
    check("short_g0_le", {39'd0, bus_if.line_end}, 40'd0);
    bus_if.word_count = 16'd20;
    cycle(1'b1, 1'b0, 32'd0);
    check("short_err_pulse", {39'd0, bus_if.alignment_error}, 40'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check("short_err_once", {39'd0, bus_if.alignment_error}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0403_0201);
    cycle(1'b0, 1'b1, 32'h0807_0605);
    check("short_next_data", bus_if.pixel_data, {10'h010, 10'h00C, 10'h009, 10'h005});

    // 5. YUV422 packet: no pixels, exactly one error pulse
    bus_if.image_data_type = 8'h1E;
    bus_if.word_count      = 16'd12;
    cycle(1'b1, 1'b0, 32'd0);
    check("yuv_ps_leftover_err", {39'd0, bus_if.alignment_error}, 40'd1);
    err_pulses = 0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'hA5A5_0000 + i);
      seen = seen | bus_if.pixel_valid;
      err_pulses += int'(bus_if.alignment_error);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      err_pulses += int'(bus_if.alignment_error);
    end
    check("yuv_no_valid", {39'd0, seen}, 40'd0);
    check("yuv_err_count", 40'(err_pulses), 40'd1);

    // 6. RAW10 stream interrupted by reset between words 3 and 4
    bus_if.image_data_type = 8'h2B;
    bus_if.word_count      = 16'd20;
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h0403_0201);
    cycle(1'b0, 1'b1, 32'h0807_0605);
    cycle(1'b0, 1'b1, 32'h0C0B_0A09);
    check("rstmid_pre_valid", {39'd0, bus_if.pixel_valid}, 40'd1);
    bus_if.image_data_enable = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", {39'd0, bus_if.pixel_valid}, 40'd0);
    check("rstmid_data", bus_if.pixel_data, 40'd0);
    check("rstmid_err", {39'd0, bus_if.alignment_error}, 40'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 32'd0);
    check("rstmid_ps_noerr", {39'd0, bus_if.alignment_error}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0403_0201);
    check("rstmid_w1_valid", {39'd0, bus_if.pixel_valid}, 40'd0);
    cycle(1'b0, 1'b1, 32'h0807_0605);
    check("rstmid_g0_data", bus_if.pixel_data, {10'h010, 10'h00C, 10'h009, 10'h005});
    check("rstmid_g0_valid", {39'd0, bus_if.pixel_valid}, 40'd1);
    cycle(1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
